// File: rtl/sum_on_7seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sum_on_7seg_pkg                                                |
// | Brief   : Shared types, segment codes and width helper for sum_on_7seg.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package sum_on_7seg_pkg;

  typedef enum logic [0:0] {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

  typedef logic [6:0] seg_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  localparam seg_t SEG_DASH = 7'b1000000;
  localparam seg_t SEG_OFF  = 7'b0000000;

  // Sum of n w-bit values fits in w + ceil(log2(n)) bits; keep at least one guard bit
  function automatic int sum_width(input int w, input int n);
    int lg;
    lg = 0;
    while ((1 << lg) < n) lg++;
    return (lg < 1) ? (w + 1) : (w + lg);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seg7_decoder                                                   |
// | Brief   : BCD digit to active-high 7-segment code; codes above 9 blank.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module seg7_decoder
  import sum_on_7seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (digit <= 4'd9) seg = SEG_DIGIT[digit];
  end

endmodule
`default_nettype wire

// File: rtl/sum_on_7seg_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sum_on_7seg_top                                                |
// | Brief   : Sums each group of N stream beats, shows result on 2 digits.   |
// |           Define SUM7SEG_OVF_DASH_EN to show "--" instead of "99" when   |
// |           the sum exceeds 99.                                            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sum_on_7seg_top
  import sum_on_7seg_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [6:0]   m_data [2]
);

  localparam int c_SW = sum_width(W, N);
  localparam int c_CW = (N > 1) ? $clog2(N) : 1;
  localparam int c_VW = (c_SW > 7) ? c_SW : 7;

  localparam logic [c_CW-1:0] c_LAST   = c_CW'(N - 1);
  localparam logic [0:0]      c_ST_ACC = ACC;
  localparam logic [0:0]      c_ST_OUT = OUT;

  logic [0:0]      r_state;
  logic [c_SW-1:0] r_acc;
  logic [c_SW-1:0] r_sum;
  logic [c_CW-1:0] r_cnt;

  logic            w_take;
  logic [c_SW-1:0] w_acc_next;

  assign s_ready    = (r_state == c_ST_ACC);
  assign m_valid    = (r_state == c_ST_OUT);
  assign w_take     = s_valid && s_ready;
  assign w_acc_next = r_acc + c_SW'(s_data);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_ST_ACC;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_ACC: begin
          if (w_take) begin
            if (r_cnt == c_LAST) begin
              r_sum   <= w_acc_next;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= c_ST_OUT;
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= r_cnt + c_CW'(1);
            end
          end
        end
        default: begin
          if (m_ready) r_state <= c_ST_ACC;
        end
      endcase
    end
  end

  // Widen to at least 7 bits so the >99 test holds for tiny W/N too
  logic [c_VW-1:0] w_sum_ext;
  logic            w_ovf;
  logic [6:0]      w_val;
  logic [3:0]      w_digit [2];
  logic [6:0]      w_seg   [2];

  assign w_sum_ext  = c_VW'(r_sum);
  assign w_ovf      = (w_sum_ext > c_VW'(99));
  assign w_val      = w_ovf ? 7'd99 : w_sum_ext[6:0];
  assign w_digit[0] = 4'(w_val % 7'd10);
  assign w_digit[1] = 4'(w_val / 7'd10);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      seg7_decoder u_dec (
        .digit (w_digit[gi]),
        .seg   (w_seg[gi])
      );
`ifdef SUM7SEG_OVF_DASH_EN
      assign m_data[gi] = w_ovf ? SEG_DASH : w_seg[gi];
`else
      assign m_data[gi] = w_seg[gi];
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sum_on_7seg_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sum_on_7seg_top                                             |
// | Brief   : Directed self-checking bench for sum_on_7seg_top.              |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sum_on_7seg_top;

  localparam logic [6:0] c_S0    = 7'b0111111;
  localparam logic [6:0] c_S2    = 7'b1011011;
  localparam logic [6:0] c_S3    = 7'b1001111;
  localparam logic [6:0] c_S5    = 7'b1101101;
  localparam logic [6:0] c_S6    = 7'b1111101;
  localparam logic [6:0] c_S9    = 7'b1101111;
  localparam logic [6:0] c_SDASH = 7'b1000000;

  logic        clk;
  logic        rstn;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [6:0]  m_data [2];

  int n_checks;
  int n_pass;

  sum_on_7seg_top #(.W(16), .N(3)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Three back-to-back beats; returns one cycle after the last is accepted
  task automatic send3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    s_valid = 1'b1; s_data = a; tick();
    s_valid = 1'b1; s_data = b; tick();
    s_valid = 1'b1; s_data = c; tick();
    s_valid = 1'b0; s_data = '0;
  endtask

  task automatic expect_out(input string tag, input logic [6:0] tens, input logic [6:0] units);
    check({tag, ".m_valid"}, 32'(m_valid), 32'd1);
    check({tag, ".s_ready"}, 32'(s_ready), 32'd0);
    check({tag, ".tens"},    32'(m_data[1]), 32'(tens));
    check({tag, ".units"},   32'(m_data[0]), 32'(units));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn     = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;

    // Beats offered during reset must be ignored
    repeat (2) tick();
    s_valid = 1'b1; s_data = 16'd50;
    repeat (2) tick();
    check("rst.m_valid", 32'(m_valid), 32'd0);
    check("rst.s_ready", 32'(s_ready), 32'd1);
    check("rst.tens",    32'(m_data[1]), 32'(c_S0));
    check("rst.units",   32'(m_data[0]), 32'(c_S0));
    s_valid = 1'b0; s_data = '0;
    rstn = 1'b1;
    tick();

    // Basic sum 3+2+1 = 06, single-cycle OUT
    send3(16'd3, 16'd2, 16'd1);
    expect_out("basic", c_S0, c_S6);
    tick();
    check("basic.after_valid", 32'(m_valid), 32'd0);
    check("basic.after_ready", 32'(s_ready), 32'd1);

    // Two-digit sum 10+7+8 = 25, then 4+1+4 = 09
    send3(16'd10, 16'd7, 16'd8);
    expect_out("two", c_S2, c_S5);
    tick();
    send3(16'd4, 16'd1, 16'd4);
    expect_out("nine", c_S0, c_S9);
    tick();

    // Backpressure: hold for 5 cycles while offering a beat that must not be taken
    m_ready = 1'b0;
    send3(16'd3, 16'd2, 16'd1);
    s_valid = 1'b1; s_data = 16'd77;
    for (int i = 0; i < 5; i++) begin
      expect_out("bp.hold", c_S0, c_S6);
      tick();
    end
    s_valid = 1'b0; s_data = '0;
    m_ready = 1'b1;
    expect_out("bp.release", c_S0, c_S6);
    tick();
    check("bp.back_acc", 32'(s_ready), 32'd1);
    check("bp.no_valid", 32'(m_valid), 32'd0);
    send3(16'd1, 16'd1, 16'd1);
    expect_out("bp.not_consumed", c_S0, c_S3);
    tick();

    // Gapped input: 3, idle x4, 2, 1 ; m_ready toggling in ACC is ignored
    s_valid = 1'b1; s_data = 16'd3; tick();
    s_valid = 1'b0; s_data = '0;
    for (int i = 0; i < 4; i++) begin
      m_ready = i[0];
      check("gap.idle_valid", 32'(m_valid), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'd2; tick();
    check("gap.mid_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b1; s_data = 16'd1; tick();
    s_valid = 1'b0; s_data = '0;
    expect_out("gap", c_S0, c_S6);
    tick();

    // Overflow: 60+30+20 = 110
    send3(16'd60, 16'd30, 16'd20);
`ifdef SUM7SEG_OVF_DASH_EN
    expect_out("ovf", c_SDASH, c_SDASH);
`else
    expect_out("ovf", c_S9, c_S9);
`endif
    tick();

    // Asynchronous reset while in OUT drops m_valid without a clock edge
    m_ready = 1'b0;
    send3(16'd5, 16'd5, 16'd5);
    check("arst.pre_valid", 32'(m_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst.m_valid", 32'(m_valid), 32'd0);
    check("arst.s_ready", 32'(s_ready), 32'd1);
    check("arst.tens",    32'(m_data[1]), 32'(c_S0));
    check("arst.units",   32'(m_data[0]), 32'(c_S0));
    m_ready = 1'b1;
    tick();
    rstn = 1'b1;
    tick();

    // Reset mid-accumulation discards 9+9; 1+1+1 afterwards gives 03
    s_valid = 1'b1; s_data = 16'd9; tick();
    s_valid = 1'b1; s_data = 16'd9; tick();
    s_valid = 1'b0; s_data = '0;
    #2 rstn = 1'b0;
    #1;
    check("mid.m_valid", 32'(m_valid), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    send3(16'd1, 16'd1, 16'd1);
    expect_out("mid", c_S0, c_S3);
    tick();
    check("mid.end_valid", 32'(m_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
